// File: rtl/br_lite_ni_if.sv
// BrLite flit/service types and the PE/NoC signal bundle of one br_lite_ni.
// slave is the NI's own view; master is the PE plus the NoC local port.
package br_pkg;
  typedef enum logic [1:0] {
    SVC_ALL = 2'd0,
    SVC_TGT = 2'd1,
    SVC_MON = 2'd2,
    SVC_CLR = 2'd3
  } br_svc_t;

  typedef struct packed {
    br_svc_t     service;
    logic [15:0] source;
    logic [15:0] target;
    logic [4:0]  id;
    logic [31:0] payload;
  } br_data_t;
endpackage

interface br_lite_ni_if;
  import br_pkg::*;

  logic        tx_valid_i;
  logic        tx_ready_o;
  logic [31:0] tx_payload_i;
  logic [15:0] tx_target_i;
  br_svc_t     tx_svc_i;

  br_data_t    noc_flit_o;
  logic        noc_req_o;
  logic        noc_ack_i;
  logic        noc_busy_i;

  br_data_t    noc_flit_i;
  logic        noc_req_i;
  logic        noc_ack_o;

  logic        rx_valid_o;
  logic        rx_ready_i;
  logic [31:0] rx_payload_o;
  logic [15:0] rx_src_o;
  br_svc_t     rx_svc_o;
  logic [4:0]  rx_id_o;

  modport slave (
    input  tx_valid_i, tx_payload_i, tx_target_i, tx_svc_i,
    output tx_ready_o,
    output noc_flit_o, noc_req_o,
    input  noc_ack_i, noc_busy_i,
    input  noc_flit_i, noc_req_i,
    output noc_ack_o,
    output rx_valid_o, rx_payload_o, rx_src_o, rx_svc_o, rx_id_o,
    input  rx_ready_i
  );

  modport master (
    output tx_valid_i, tx_payload_i, tx_target_i, tx_svc_i,
    input  tx_ready_o,
    input  noc_flit_o, noc_req_o,
    output noc_ack_i, noc_busy_i,
    output noc_flit_i, noc_req_i,
    input  noc_ack_o,
    input  rx_valid_o, rx_payload_o, rx_src_o, rx_svc_o, rx_id_o,
    output rx_ready_i
  );
endinterface

// File: rtl/br_lite_ni.sv
// PE-side network interface for a BrLite local port: TX FIFO + 4-phase injector,
// 4-phase receiver + RX FIFO presented to the PE over valid/ready.
module br_lite_ni
  import br_pkg::*;
#(
  parameter int X_CNT    = 4,
  parameter int Y_CNT    = 4,
  parameter int PE_ID    = 0,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  br_lite_ni_if.slave ni
);

  localparam int TXW = $clog2(TX_DEPTH);
  localparam int RXW = $clog2(RX_DEPTH);

  function automatic logic [15:0] idx2xy(input logic [31:0] idx);
    logic [7:0] x;
    logic [7:0] y;
    x = 8'(idx % X_CNT);
    y = 8'(idx / X_CNT);
    return {x, y};
  endfunction

  function automatic logic [15:0] xy2idx(input logic [15:0] xy);
    return 16'(32'(xy[15:8]) + 32'(xy[7:0]) * X_CNT);
  endfunction

  localparam logic [15:0] SRC_XY = idx2xy(32'(PE_ID % (X_CNT * Y_CNT)));

  typedef struct packed {
    br_svc_t     svc;
    logic [15:0] tgt;
    logic [31:0] payload;
  } tx_ent_t;

  typedef struct packed {
    br_svc_t     svc;
    logic [4:0]  id;
    logic [15:0] src;
    logic [31:0] payload;
  } rx_ent_t;

  typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_REL} tx_state_t;

  tx_ent_t        tx_mem [TX_DEPTH];
  logic [TXW-1:0] tx_wr_q, tx_rd_q;
  logic [TXW:0]   tx_cnt_q;
  logic           tx_full, tx_empty, tx_push, tx_pop;
  tx_ent_t        tx_head;

  tx_state_t      tx_state_q, tx_state_d;
  br_data_t       flit_q, flit_d;
  logic           req_q, req_d;
  logic [4:0]     id_q, id_d;

  assign tx_full  = (tx_cnt_q == (TXW+1)'(TX_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_push  = ni.tx_valid_i && !tx_full;
  assign tx_head  = tx_mem[tx_rd_q];

  assign ni.tx_ready_o = !tx_full;
  assign ni.noc_flit_o = flit_q;
  assign ni.noc_req_o  = req_q;

  // Target is converted to XY at push; the id is only bound at launch.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q] <= '{svc: ni.tx_svc_i, tgt: idx2xy(32'(ni.tx_target_i)),
                                      payload: ni.tx_payload_i};
  end

  always_comb begin
    tx_state_d = tx_state_q;
    flit_d     = flit_q;
    req_d      = req_q;
    id_d       = id_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty && !ni.noc_busy_i) begin
          flit_d     = '{service: tx_head.svc, source: SRC_XY, target: tx_head.tgt,
                         id: id_q, payload: tx_head.payload};
          req_d      = 1'b1;
          tx_state_d = TX_REQ;
        end
      end
      TX_REQ: begin
        if (ni.noc_ack_i) begin
          req_d      = 1'b0;
          tx_pop     = 1'b1;
          id_d       = id_q + 5'd1;
          tx_state_d = TX_REL;
        end
      end
      TX_REL: begin
        if (!ni.noc_ack_i) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      flit_q     <= '0;
      req_q      <= 1'b0;
      id_q       <= '0;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_cnt_q   <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      flit_q     <= flit_d;
      req_q      <= req_d;
      id_q       <= id_d;
      tx_wr_q    <= tx_wr_q + TXW'(tx_push);
      tx_rd_q    <= tx_rd_q + TXW'(tx_pop);
      tx_cnt_q   <= tx_cnt_q + (TXW+1)'(tx_push) - (TXW+1)'(tx_pop);
    end
  end

  rx_ent_t        rx_mem [RX_DEPTH];
  logic [RXW-1:0] rx_wr_q, rx_rd_q;
  logic [RXW:0]   rx_cnt_q;
  logic           rx_full, rx_empty, rx_push, rx_pop;
  logic           ack_q, ack_d;
  rx_ent_t        rx_head;
  logic           unused_flit_target;

  assign rx_full  = (rx_cnt_q == (RXW+1)'(RX_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);
  // Full is the registered occupancy, so a same-cycle pop defers the write one cycle.
  assign rx_push  = ni.noc_req_i && !ack_q && !rx_full;
  assign rx_pop   = !rx_empty && ni.rx_ready_i;
  assign rx_head  = rx_empty ? '0 : rx_mem[rx_rd_q];

  assign unused_flit_target = ^ni.noc_flit_i.target;

  always_comb begin
    ack_d = ack_q;
    if (rx_push)             ack_d = 1'b1;
    else if (!ni.noc_req_i)  ack_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_q] <= '{svc: ni.noc_flit_i.service, id: ni.noc_flit_i.id,
                                      src: xy2idx(ni.noc_flit_i.source),
                                      payload: ni.noc_flit_i.payload};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q    <= 1'b0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      ack_q    <= ack_d;
      rx_wr_q  <= rx_wr_q + RXW'(rx_push);
      rx_rd_q  <= rx_rd_q + RXW'(rx_pop);
      rx_cnt_q <= rx_cnt_q + (RXW+1)'(rx_push) - (RXW+1)'(rx_pop);
    end
  end

  assign ni.noc_ack_o   = ack_q;
  assign ni.rx_valid_o  = !rx_empty;
  assign ni.rx_payload_o = rx_head.payload;
  assign ni.rx_src_o    = rx_head.src;
  assign ni.rx_svc_o    = rx_head.svc;
  assign ni.rx_id_o     = rx_head.id;

endmodule

// File: tb/tb_br_lite_ni.sv
// Directed bench for br_lite_ni: queue-based reference model checked every cycle,
// plus literal expectations for the handshake timing, coordinates and id sequence.
module tb_br_lite_ni;
  import br_pkg::*;

  localparam int XC = 4, YC = 4, PE = 5, TXD = 4, RXD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  br_lite_ni_if bus();

  br_lite_ni #(.X_CNT(XC), .Y_CNT(YC), .PE_ID(PE), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ni   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timed_out(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  function automatic logic [15:0] to_xy(input int idx);
    return 16'(((idx % XC) << 8) | (idx / XC));
  endfunction

  function automatic logic [15:0] to_idx(input logic [15:0] xy);
    return 16'(int'(xy[15:8]) + int'(xy[7:0]) * XC);
  endfunction

  // Reference model: messages as queues, handshake phase as a small integer.
  typedef struct { logic [31:0] payload; logic [15:0] target; br_svc_t svc; } tx_msg_t;
  typedef struct { logic [31:0] payload; logic [15:0] src; br_svc_t svc; logic [4:0] id; } rx_msg_t;

  tx_msg_t  m_txq[$];
  rx_msg_t  m_rxq[$];
  int       m_phase = 0;
  logic     m_req = 1'b0;
  logic     m_ack = 1'b0;
  br_data_t m_flit = '0;
  int       m_id = 0;

  initial begin
    tx_msg_t t;
    rx_msg_t r;
    bit      tpush, rcap, rpop;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_txq.delete(); m_rxq.delete();
        m_phase = 0; m_req = 1'b0; m_ack = 1'b0; m_flit = '0; m_id = 0;
      end else begin
        tpush = bus.tx_valid_i && (m_txq.size() < TXD);
        if (m_phase == 1 && bus.noc_ack_i) begin
          void'(m_txq.pop_front());
          m_req = 1'b0; m_id = (m_id + 1) % 32; m_phase = 2;
        end else if (m_phase == 2 && !bus.noc_ack_i) begin
          m_phase = 0;
        end else if (m_phase == 0 && m_txq.size() > 0 && !bus.noc_busy_i) begin
          m_flit = '{service: m_txq[0].svc, source: to_xy(PE), target: to_xy(int'(m_txq[0].target)),
                     id: 5'(m_id), payload: m_txq[0].payload};
          m_req = 1'b1; m_phase = 1;
        end
        if (tpush) begin
          t.payload = bus.tx_payload_i; t.target = bus.tx_target_i; t.svc = bus.tx_svc_i;
          m_txq.push_back(t);
        end
        rpop = (m_rxq.size() > 0) && bus.rx_ready_i;
        rcap = bus.noc_req_i && !m_ack && (m_rxq.size() < RXD);
        if (rpop) void'(m_rxq.pop_front());
        if (rcap) begin
          r.payload = bus.noc_flit_i.payload; r.src = to_idx(bus.noc_flit_i.source);
          r.svc = bus.noc_flit_i.service; r.id = bus.noc_flit_i.id;
          m_rxq.push_back(r);
          m_ack = 1'b1;
        end else if (!bus.noc_req_i) begin
          m_ack = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("tx_ready", 128'(bus.tx_ready_o), 128'(m_txq.size() < TXD));
        check("noc_req", 128'(bus.noc_req_o), 128'(m_req));
        if (m_req) check("noc_flit", 128'(bus.noc_flit_o), 128'(m_flit));
        check("noc_ack", 128'(bus.noc_ack_o), 128'(m_ack));
        check("rx_valid", 128'(bus.rx_valid_o), 128'(m_rxq.size() > 0));
        if (m_rxq.size() > 0) begin
          check("rx_payload", 128'(bus.rx_payload_o), 128'(m_rxq[0].payload));
          check("rx_src", 128'(bus.rx_src_o), 128'(m_rxq[0].src));
          check("rx_svc", 128'(bus.rx_svc_o), 128'(m_rxq[0].svc));
          check("rx_id", 128'(bus.rx_id_o), 128'(m_rxq[0].id));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic push_msg(input logic [31:0] p, input logic [15:0] t, input br_svc_t s);
    bus.tx_valid_i = 1'b1; bus.tx_payload_i = p; bus.tx_target_i = t; bus.tx_svc_i = s;
    tick();
    bus.tx_valid_i = 1'b0;
  endtask

  // NoC side of one injection: accept the pending request, release when it drops.
  task automatic serve_tx(output logic [4:0] id, output logic [31:0] pl);
    int n;
    n = 0; id = '1; pl = '0;
    @(negedge clk);
    while (!bus.noc_req_o && n < 200) begin @(negedge clk); n++; end
    if (!bus.noc_req_o) begin timed_out("tx_req_wait"); return; end
    id = bus.noc_flit_o.id;
    pl = bus.noc_flit_o.payload;
    bus.noc_ack_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (bus.noc_req_o && n < 200) begin @(negedge clk); n++; end
    if (bus.noc_req_o) timed_out("tx_req_release");
    bus.noc_ack_i = 1'b0;
  endtask

  task automatic deliver(input logic [15:0] src_xy, input logic [31:0] pl, input logic [4:0] id);
    int n;
    bus.noc_flit_i = '{service: SVC_ALL, source: src_xy, target: to_xy(PE), id: id, payload: pl};
    bus.noc_req_i = 1'b1;
    n = 0;
    tick();
    while (!bus.noc_ack_o && n < 100) begin tick(); n++; end
    if (!bus.noc_ack_o) timed_out("rx_ack_wait");
    bus.noc_req_i = 1'b0;
    n = 0;
    tick();
    while (bus.noc_ack_o && n < 100) begin tick(); n++; end
    if (bus.noc_ack_o) timed_out("rx_ack_release");
  endtask

  initial begin
    logic [4:0]  got_id;
    logic [31:0] got_pl;

    bus.tx_valid_i = 1'b0; bus.tx_payload_i = '0; bus.tx_target_i = '0; bus.tx_svc_i = SVC_ALL;
    bus.noc_ack_i = 1'b0; bus.noc_busy_i = 1'b0;
    bus.noc_flit_i = '0; bus.noc_req_i = 1'b0; bus.rx_ready_i = 1'b0;

    tick();
    tick();
    check("rst_tx_ready", 128'(bus.tx_ready_o), 128'(1));
    check("rst_noc_req", 128'(bus.noc_req_o), 128'(0));
    check("rst_noc_flit", 128'(bus.noc_flit_o), 128'(0));
    check("rst_noc_ack", 128'(bus.noc_ack_o), 128'(0));
    check("rst_rx_valid", 128'(bus.rx_valid_o), 128'(0));
    check("rst_rx_payload", 128'(bus.rx_payload_o), 128'(0));
    check("rst_rx_src", 128'(bus.rx_src_o), 128'(0));
    check("rst_rx_svc", 128'(bus.rx_svc_o), 128'(0));
    check("rst_rx_id", 128'(bus.rx_id_o), 128'(0));
    #2 rst_n = 1'b1;
    tick();

    // Single targeted send: PE 5 -> (1,1), target 10 -> (2,2)
    push_msg(32'hDEADBEEF, 16'd10, SVC_TGT);
    check("t1_req_at_push", 128'(bus.noc_req_o), 128'(0));
    tick();
    check("t1_req_rise", 128'(bus.noc_req_o), 128'(1));
    check("t1_src", 128'(bus.noc_flit_o.source), 128'(16'h0101));
    check("t1_tgt", 128'(bus.noc_flit_o.target), 128'(16'h0202));
    check("t1_id", 128'(bus.noc_flit_o.id), 128'(0));
    check("t1_payload", 128'(bus.noc_flit_o.payload), 128'(32'hDEADBEEF));
    tick();
    tick();
    check("t1_req_held", 128'(bus.noc_req_o), 128'(1));
    bus.noc_ack_i = 1'b1;
    tick();
    check("t1_req_fall", 128'(bus.noc_req_o), 128'(0));
    check("t1_tx_ready", 128'(bus.tx_ready_o), 128'(1));
    bus.noc_ack_i = 1'b0;
    tick();
    tick();

    // Busy gating
    bus.noc_busy_i = 1'b1;
    push_msg(32'h0000_0B05, 16'd3, SVC_ALL);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t2_req_busy", 128'(bus.noc_req_o), 128'(0));
    end
    bus.noc_busy_i = 1'b0;
    tick();
    check("t2_req_after_busy", 128'(bus.noc_req_o), 128'(1));
    check("t2_id", 128'(bus.noc_flit_o.id), 128'(1));
    bus.noc_ack_i = 1'b1;
    tick();
    bus.noc_ack_i = 1'b0;
    tick();
    tick();

    // TX backpressure and id wrap over 33 injections
    do_reset();
    bus.noc_busy_i = 1'b1;
    bus.tx_valid_i = 1'b1; bus.tx_svc_i = SVC_TGT;
    for (int i = 0; i < 4; i++) begin
      bus.tx_payload_i = 32'(i); bus.tx_target_i = 16'(i);
      tick();
    end
    bus.tx_valid_i = 1'b0;
    check("t3_full_ready", 128'(bus.tx_ready_o), 128'(0));
    tick();
    check("t3_full_ready_hold", 128'(bus.tx_ready_o), 128'(0));
    bus.noc_busy_i = 1'b0;
    fork
      begin
        for (int i = 4; i < 33; i++) begin
          int n;
          n = 0;
          @(negedge clk);
          while (!bus.tx_ready_o && n < 500) begin @(negedge clk); n++; end
          if (!bus.tx_ready_o) timed_out("t3_push_wait");
          bus.tx_valid_i = 1'b1; bus.tx_payload_i = 32'(i); bus.tx_target_i = 16'(i % 16);
          @(posedge clk);
          #1 bus.tx_valid_i = 1'b0;
        end
      end
      begin
        for (int k = 0; k < 33; k++) begin
          serve_tx(got_id, got_pl);
          check("t3_id_seq", 128'(got_id), 128'(k % 32));
          check("t3_payload_seq", 128'(got_pl), 128'(k));
        end
      end
    join
    tick();
    tick();

    // RX delivery: source (3,2) -> index 11
    bus.rx_ready_i = 1'b1;
    bus.noc_flit_i = '{service: SVC_MON, source: 16'h0302, target: to_xy(PE), id: 5'd9,
                       payload: 32'h12345678};
    bus.noc_req_i = 1'b1;
    tick();
    check("t4_ack_rise", 128'(bus.noc_ack_o), 128'(1));
    check("t4_rx_valid", 128'(bus.rx_valid_o), 128'(1));
    check("t4_rx_src", 128'(bus.rx_src_o), 128'(11));
    check("t4_rx_payload", 128'(bus.rx_payload_o), 128'(32'h12345678));
    tick();
    check("t4_ack_hold", 128'(bus.noc_ack_o), 128'(1));
    check("t4_rx_popped", 128'(bus.rx_valid_o), 128'(0));
    bus.noc_req_i = 1'b0;
    tick();
    check("t4_ack_fall", 128'(bus.noc_ack_o), 128'(0));
    tick();

    // RX backpressure: four fill the FIFO, the fifth waits for a pop
    bus.rx_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) deliver(to_xy(i), 32'hA0 + 32'(i), 5'(i));
    bus.noc_flit_i = '{service: SVC_CLR, source: to_xy(15), target: to_xy(PE), id: 5'd4,
                       payload: 32'hA4};
    bus.noc_req_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_ack_withheld", 128'(bus.noc_ack_o), 128'(0));
    end
    bus.rx_ready_i = 1'b1;
    tick();
    bus.rx_ready_i = 1'b0;
    check("t5_ack_on_pop_edge", 128'(bus.noc_ack_o), 128'(0));
    tick();
    check("t5_ack_after_pop", 128'(bus.noc_ack_o), 128'(1));
    bus.noc_req_i = 1'b0;
    tick();
    tick();
    for (int k = 1; k < 5; k++) begin
      check("t5_order", 128'(bus.rx_payload_o), 128'(32'hA0 + 32'(k)));
      bus.rx_ready_i = 1'b1;
      tick();
      bus.rx_ready_i = 1'b0;
    end
    check("t5_drained", 128'(bus.rx_valid_o), 128'(0));

    // Reset during TX_REQ
    deliver(16'h0100, 32'h55, 5'd1);
    push_msg(32'h77, 16'd1, SVC_TGT);
    push_msg(32'h78, 16'd2, SVC_TGT);
    check("t6_in_req", 128'(bus.noc_req_o), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    check("t6_req_drop", 128'(bus.noc_req_o), 128'(0));
    check("t6_tx_empty", 128'(bus.tx_ready_o), 128'(1));
    check("t6_rx_empty", 128'(bus.rx_valid_o), 128'(0));
    check("t6_flit_clr", 128'(bus.noc_flit_o), 128'(0));
    tick();
    #2 rst_n = 1'b1;
    tick();
    push_msg(32'h99, 16'd7, SVC_ALL);
    serve_tx(got_id, got_pl);
    check("t6_id_after_rst", 128'(got_id), 128'(0));
    check("t6_payload_after_rst", 128'(got_pl), 128'(32'h99));
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
